// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: parallel-side and line-side signal bundle of the buffered UART transmitter
// Ports (via modports):
//   par_en, par_typ, stop2, prescale : frame configuration, sampled by the transmitter on each pop
//   data_valid, p_data, data_ready   : word write handshake into the input FIFO
//   tx_out, busy, fifo_count         : serial line, frame-in-progress flag, queued word count
//   master drives config/data, slave is the transmitter
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int CNT_WIDTH      = 3
);
    logic                      par_en;
    logic                      par_typ;
    logic                      stop2;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      data_valid;
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_ready;
    logic                      tx_out;
    logic                      busy;
    logic [CNT_WIDTH-1:0]      fifo_count;

    modport master (
        output par_en, par_typ, stop2, prescale, data_valid, p_data,
        input  data_ready, tx_out, busy, fifo_count
    );

    modport slave (
        input  par_en, par_typ, stop2, prescale, data_valid, p_data,
        output data_ready, tx_out, busy, fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART serial transmitter with an input FIFO and back-to-back framing
// Ports:
//   clk_i : UART clock
//   rst_i : asynchronous reset, active-high; clears the FIFO and aborts any frame
//   bus   : uart_tx_fifo_if.slave (config, write handshake, tx_out, busy, fifo_count)
module uart_tx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 6,
    parameter int CNT_WIDTH      = $clog2(FIFO_DEPTH) + 1
) (
    input logic           clk_i,
    input logic           rst_i,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]      count_q;
    logic [DATA_WIDTH-1:0]     sh_q, sh_d;
    logic                      par_en_q, par_bit_q, stop2_q;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d, cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      tx_q, tx_d;
    logic                      full, empty, push, pop, bit_done, last_data, last_stop;
    logic [DATA_WIDTH-1:0]     head;

    assign full      = count_q == CNT_WIDTH'(FIFO_DEPTH);
    assign empty     = count_q == '0;
    assign push      = bus.data_valid && !full;
    assign head      = mem_q[rd_ptr_q];
    assign bit_done  = cnt_q == '0;
    assign last_data = idx_q == IW'(DATA_WIDTH - 1);
    assign last_stop = idx_q == IW'(stop2_q);

    assign bus.data_ready = !full;
    assign bus.tx_out     = tx_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.fifo_count = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A pop either starts a frame from IDLE or chains the next frame
    // directly out of the final stop bit, so no idle cycle separates them.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:    pop = !empty;
            START:   if (bit_done) state_d = DATA;
            DATA:    if (bit_done && last_data) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_done) state_d = STOP;
            STOP:    if (bit_done && last_stop) begin
                         pop     = !empty;
                         state_d = IDLE;
                     end
            default: state_d = IDLE;
        endcase
        if (pop) state_d = START;
    end

    // Bit period counts down from prescale-1; idx counts data bits in DATA
    // and stop bits in STOP, restarting on every state change.
    always_comb begin
        pre_d = pop ? ((bus.prescale == '0) ? PRE_ONE : bus.prescale) : pre_q;
        sh_d  = pop ? head : (state_q == DATA && bit_done) ? sh_q >> 1 : sh_q;
        cnt_d = (state_d == IDLE) ? '0 : (pop || bit_done) ? pre_d - PRE_ONE : cnt_q - PRE_ONE;
        idx_d = (state_d != state_q) ? '0 : bit_done ? idx_q + IW'(1) : idx_q;
    end

    // The line level is computed for the state being entered, so tx_q
    // changes on the same edge as the state and stays glitch-free.
    always_comb begin
        tx_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? sh_d[0] :
               (state_d == PARITY) ? par_bit_q : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.p_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sh_q      <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            pre_q     <= PRE_ONE;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
        end else begin
            count_q <= count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
            sh_q    <= sh_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                par_en_q  <= bus.par_en;
                stop2_q   <= bus.stop2;
                par_bit_q <= (^head) ^ bus.par_typ;
            end
        end
    end
endmodule
